// File: rtl/ux607_regvec_pkg.sv
// Shared types for the ux607 register-vector write scheduler.
// State encoding, requester source encoding and address-width helper.
package ux607_regvec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic SRC_BUS = 1'b0;
    localparam logic SRC_HW  = 1'b1;

    // Smallest index width able to address n register instances.
    function automatic int regvec_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ux607_rr_arb2.sv
// Two-way round-robin arbiter; req[0]=bus, req[1]=hw.
// On a tie the requester that did not win last time is granted.
module ux607_rr_arb2
    import ux607_regvec_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_grant;

    // Grant is purely combinational from the requests and history bit.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == SRC_HW) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember who won the most recent accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= SRC_HW;
        end else if (en) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/ux607_regvec_wr_sched.sv
// Bus/hw access scheduler for a bank of register-vector instances.
// Merges masked writes and issues single-cycle enable pulses.
module ux607_regvec_wr_sched
    import ux607_regvec_pkg::*;
#(
    parameter int NREGS = 6,
    parameter int DW    = 32,
    parameter int AW    = regvec_aw(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                bus_req_valid,
    output logic                bus_req_ready,
    input  logic                bus_req_write,
    input  logic [AW-1:0]       bus_req_addr,
    input  logic [DW-1:0]       bus_req_wdata,
    input  logic [DW-1:0]       bus_req_wmask,
    output logic                bus_rsp_valid,
    input  logic                bus_rsp_ready,
    output logic [DW-1:0]       bus_rsp_rdata,
    output logic                bus_rsp_err,
    input  logic                hw_req_valid,
    output logic                hw_req_ready,
    input  logic [AW-1:0]       hw_req_addr,
    input  logic [DW-1:0]       hw_req_wdata,
    input  logic [DW-1:0]       hw_req_wmask,
    output logic                hw_ack,
    output logic [NREGS-1:0]    reg_en,
    output logic [NREGS*DW-1:0] reg_d,
    input  logic [NREGS*DW-1:0] reg_q
);

    state_t           state;
    state_t           next;
    logic [1:0]       grant;
    logic             idle;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic [DW-1:0]    sel_wmask;
    logic             sel_write;
    logic             oor;
    logic [DW-1:0]    cur_q;
    logic [DW-1:0]    merged;
    logic [NREGS-1:0] onehot;
    logic [DW-1:0]    merged_q;
    logic             src_q;
    logic             err_q;

    assign idle = (state == IDLE) && !reset;

    ux607_rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({hw_req_valid, bus_req_valid}),
        .en    (accept),
        .grant (grant)
    );

    assign bus_req_ready = idle && grant[0];
    assign hw_req_ready  = idle && grant[1];
    assign accept        = bus_req_ready || hw_req_ready;

    // Steer the granted requester onto the shared request fields.
    always_comb begin
        sel_addr  = bus_req_addr;
        sel_wdata = bus_req_wdata;
        sel_wmask = bus_req_wmask;
        sel_write = bus_req_write;
        if (grant[1]) begin
            sel_addr  = hw_req_addr;
            sel_wdata = hw_req_wdata;
            sel_wmask = hw_req_wmask;
            sel_write = 1'b1;
        end
    end

    // Decode the index, fetch current contents and merge under mask.
    always_comb begin
        onehot = '0;
        cur_q  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel_addr == AW'(i)) begin
                onehot[i] = 1'b1;
                cur_q     = reg_q[i*DW +: DW];
            end
        end
        oor    = ~|onehot;
        merged = (cur_q & ~sel_wmask) | (sel_wdata & sel_wmask);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state selection.
    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next = sel_write ? WRITE : RESP;
                end
            end
            WRITE: begin
                next = (src_q == SRC_HW) ? IDLE : RESP;
            end
            RESP: begin
                if (bus_rsp_ready) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Registered outputs and captured transaction fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_en        <= '0;
            hw_ack        <= 1'b0;
            bus_rsp_valid <= 1'b0;
            bus_rsp_rdata <= '0;
            bus_rsp_err   <= 1'b0;
            merged_q      <= '0;
            src_q         <= SRC_BUS;
            err_q         <= 1'b0;
        end else begin
            reg_en <= '0;
            hw_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        src_q    <= grant[1];
                        err_q    <= oor;
                        merged_q <= merged;
                        if (sel_write) begin
                            reg_en <= onehot;
                            hw_ack <= grant[1];
                        end else begin
                            bus_rsp_valid <= 1'b1;
                            bus_rsp_rdata <= oor ? '0 : cur_q;
                            bus_rsp_err   <= oor;
                        end
                    end
                end
                WRITE: begin
                    if (src_q == SRC_BUS) begin
                        bus_rsp_valid <= 1'b1;
                        bus_rsp_rdata <= err_q ? '0 : merged_q;
                        bus_rsp_err   <= err_q;
                    end
                end
                RESP: begin
                    if (bus_rsp_ready) begin
                        bus_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every slice carries the merged word; only the enabled one matters.
    assign reg_d = {NREGS{merged_q}};

endmodule

// File: tb/tb_ux607_regvec_wr_sched.sv
// Directed bench for ux607_regvec_wr_sched.
// Register instances are modelled as simple enable-loaded words.
module tb_ux607_regvec_wr_sched;

    localparam int NREGS = 6;
    localparam int DW    = 32;
    localparam int AW    = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                bus_req_valid = 1'b0;
    logic                bus_req_ready;
    logic                bus_req_write = 1'b0;
    logic [AW-1:0]       bus_req_addr = '0;
    logic [DW-1:0]       bus_req_wdata = '0;
    logic [DW-1:0]       bus_req_wmask = '0;
    logic                bus_rsp_valid;
    logic                bus_rsp_ready = 1'b0;
    logic [DW-1:0]       bus_rsp_rdata;
    logic                bus_rsp_err;
    logic                hw_req_valid = 1'b0;
    logic                hw_req_ready;
    logic [AW-1:0]       hw_req_addr = '0;
    logic [DW-1:0]       hw_req_wdata = '0;
    logic [DW-1:0]       hw_req_wmask = '0;
    logic                hw_ack;
    logic [NREGS-1:0]    reg_en;
    logic [NREGS*DW-1:0] reg_d;
    logic [NREGS*DW-1:0] reg_q;

    logic [DW-1:0] regs [NREGS] = '{default: '0};

    int n_total = 0;
    int n_pass  = 0;

    ux607_regvec_wr_sched #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_write (bus_req_write),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wmask (bus_req_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_ready (bus_rsp_ready),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err),
        .hw_req_valid  (hw_req_valid),
        .hw_req_ready  (hw_req_ready),
        .hw_req_addr   (hw_req_addr),
        .hw_req_wdata  (hw_req_wdata),
        .hw_req_wmask  (hw_req_wmask),
        .hw_ack        (hw_ack),
        .reg_en        (reg_en),
        .reg_d         (reg_d),
        .reg_q         (reg_q)
    );

    always #5 clock = ~clock;

    // Register-vector instances: load slice on enable.
    always @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reg_en[i]) regs[i] <= reg_d[i*DW +: DW];
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) reg_q[i*DW +: DW] = regs[i];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rsp_handshake();
        bus_rsp_ready = 1'b1;
        tick();
        bus_rsp_ready = 1'b0;
        check("rsp_done", bus_rsp_valid, 0);
    endtask

    // Lone bus write through accept, enable pulse and response.
    task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] wm, input logic [NREGS-1:0] en,
                          input logic [DW-1:0] exp, input logic err);
        bus_req_valid = 1'b1;
        bus_req_write = 1'b1;
        bus_req_addr  = a;
        bus_req_wdata = wd;
        bus_req_wmask = wm;
        #1;
        check("wr_rdy", bus_req_ready, 1);
        tick();
        bus_req_valid = 1'b0;
        check("wr_en", reg_en, en);
        if (!err) check("wr_d", reg_d[int'(a)*DW +: DW], exp);
        check("wr_vld_early", bus_rsp_valid, 0);
        tick();
        check("wr_en_off", reg_en, 0);
        check("wr_vld", bus_rsp_valid, 1);
        check("wr_rdata", bus_rsp_rdata, err ? 32'h0 : exp);
        check("wr_err", bus_rsp_err, err);
        rsp_handshake();
    endtask

    // Lone bus read; response appears one cycle after accept.
    task automatic bus_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input logic err);
        bus_req_valid = 1'b1;
        bus_req_write = 1'b0;
        bus_req_addr  = a;
        #1;
        check("rd_rdy", bus_req_ready, 1);
        tick();
        bus_req_valid = 1'b0;
        check("rd_en", reg_en, 0);
        check("rd_vld", bus_rsp_valid, 1);
        check("rd_rdata", bus_rsp_rdata, exp);
        check("rd_err", bus_rsp_err, err);
        rsp_handshake();
    endtask

    task automatic hw_drive(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] wm);
        hw_req_valid = 1'b1;
        hw_req_addr  = a;
        hw_req_wdata = wd;
        hw_req_wmask = wm;
    endtask

    initial begin
        // Reset with both requesters active: nothing may be accepted.
        bus_req_valid = 1'b1;
        hw_req_valid  = 1'b1;
        repeat (3) tick();
        check("rst_bus_rdy", bus_req_ready, 0);
        check("rst_hw_rdy", hw_req_ready, 0);
        check("rst_en", reg_en, 0);
        check("rst_vld", bus_rsp_valid, 0);
        check("rst_rdata", bus_rsp_rdata, 0);
        check("rst_err", bus_rsp_err, 0);
        check("rst_ack", hw_ack, 0);
        bus_req_valid = 1'b0;
        hw_req_valid  = 1'b0;
        reset = 1'b0;
        tick();

        // Full-mask write, then preload and masked merge.
        bus_wr(3'd3, 32'hA5A5A5A5, 32'hFFFFFFFF, 6'b001000, 32'hA5A5A5A5, 0);
        check("reg3", regs[3], 32'hA5A5A5A5);
        bus_wr(3'd1, 32'h12345678, 32'hFFFFFFFF, 6'b000010, 32'h12345678, 0);
        bus_wr(3'd1, 32'hFFFF0000, 32'h00FF0000, 6'b000010, 32'h12FF5678, 0);
        bus_wr(3'd1, 32'hDEADBEEF, 32'h00000000, 6'b000010, 32'h12FF5678, 0);

        // Fresh reset, then a tie: bus first, hw at the next IDLE.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_req_valid = 1'b1;
        bus_req_write = 1'b1;
        bus_req_addr  = 3'd0;
        bus_req_wdata = 32'h11111111;
        bus_req_wmask = 32'hFFFFFFFF;
        hw_drive(3'd2, 32'h22222222, 32'hFFFFFFFF);
        #1;
        check("tie_bus_rdy", bus_req_ready, 1);
        check("tie_hw_rdy", hw_req_ready, 0);
        tick();
        bus_req_valid = 1'b0;
        check("tie_en0", reg_en, 6'b000001);
        check("tie_ack0", hw_ack, 0);
        check("tie_hw_rdy_w", hw_req_ready, 0);
        tick();
        check("tie_vld", bus_rsp_valid, 1);
        check("tie_hw_rdy_r", hw_req_ready, 0);
        rsp_handshake();
        check("hw_rdy_idle", hw_req_ready, 1);
        tick();
        hw_req_valid = 1'b0;
        check("hw_en2", reg_en, 6'b000100);
        check("hw_ack", hw_ack, 1);
        check("hw_d2", reg_d[2*DW +: DW], 32'h22222222);
        tick();
        check("hw_ack_off", hw_ack, 0);
        check("hw_en_off", reg_en, 0);
        check("reg2", regs[2], 32'h22222222);

        // Tie again after hw won: bus must win.
        bus_req_valid = 1'b1;
        bus_req_write = 1'b0;
        bus_req_addr  = 3'd2;
        hw_drive(3'd4, 32'h44444444, 32'hFFFFFFFF);
        #1;
        check("tie2_bus_rdy", bus_req_ready, 1);
        check("tie2_hw_rdy", hw_req_ready, 0);
        tick();
        bus_req_valid = 1'b0;
        check("tie2_rdata", bus_rsp_rdata, 32'h22222222);
        rsp_handshake();
        check("tie2_hw_rdy_i", hw_req_ready, 1);
        tick();
        hw_req_valid = 1'b0;
        check("hw_en4", reg_en, 6'b010000);
        tick();

        // Out-of-range accesses from both ports.
        bus_rd(3'd7, 32'h0, 1);
        hw_drive(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        check("oor_hw_rdy", hw_req_ready, 1);
        tick();
        hw_req_valid = 1'b0;
        check("oor_hw_ack", hw_ack, 1);
        check("oor_hw_en", reg_en, 0);
        tick();
        check("oor_hw_ack_off", hw_ack, 0);

        // Response back-pressure; hw waits throughout.
        bus_req_valid = 1'b1;
        bus_req_write = 1'b0;
        bus_req_addr  = 3'd2;
        hw_drive(3'd5, 32'h55555555, 32'hFFFFFFFF);
        #1;
        check("bp_bus_rdy", bus_req_ready, 1);
        tick();
        bus_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", bus_rsp_valid, 1);
            check("bp_rdata", bus_rsp_rdata, 32'h22222222);
            check("bp_hw_rdy", hw_req_ready, 0);
            tick();
        end
        bus_rsp_ready = 1'b1;
        #1;
        check("bp_hw_rdy_hs", hw_req_ready, 0);
        tick();
        bus_rsp_ready = 1'b0;
        check("bp_vld_off", bus_rsp_valid, 0);
        check("bp_hw_rdy_idle", hw_req_ready, 1);
        tick();
        hw_req_valid = 1'b0;
        check("bp_hw_en5", reg_en, 6'b100000);
        check("bp_hw_ack", hw_ack, 1);
        tick();

        // Reset during a bus WRITE cycle.
        bus_req_valid = 1'b1;
        bus_req_write = 1'b1;
        bus_req_addr  = 3'd4;
        bus_req_wdata = 32'h0F0F0F0F;
        bus_req_wmask = 32'hFFFFFFFF;
        tick();
        bus_req_valid = 1'b0;
        check("rw_en", reg_en, 6'b010000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_en_off", reg_en, 0);
        check("rw_vld", bus_rsp_valid, 0);
        tick();
        check("rw_vld2", bus_rsp_valid, 0);
        check("rw_en2", reg_en, 0);
        bus_req_valid = 1'b1;
        bus_req_write = 1'b0;
        bus_req_addr  = 3'd3;
        hw_drive(3'd0, 32'h0, 32'h0);
        #1;
        check("rw_tie_bus", bus_req_ready, 1);
        check("rw_tie_hw", hw_req_ready, 0);
        tick();
        bus_req_valid = 1'b0;
        hw_req_valid  = 1'b0;
        check("rw_rdata", bus_rsp_rdata, 32'hA5A5A5A5);
        rsp_handshake();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
